eddy_sensor_reader: RTL and testbench



---
 rtl/eddy_sensor_reader.sv | 160 ++++++++++++++++
 tb/tb_eddy_sensor_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eddy_sensor_reader.sv
// rtl/eddy_sensor_reader.sv - eddy-current X/Y SPI ADC reader with trigger/enable/done handshake
// One acquisition per accepted trigger: cnv pulse, then DATA_BITS sclk periods sampling both channels.
module eddy_sensor_reader #(
  parameter int DATA_BITS   = 18,
  parameter int SCLK_DIV    = 4,
  parameter int CONV_CYCLES = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trigger,
  input  logic                 en,
  input  logic                 miso_x,
  input  logic                 miso_y,
  output logic                 cnv,
  output logic                 sclk,
  output logic [DATA_BITS-1:0] data_x,
  output logic [DATA_BITS-1:0] data_y,
  output logic                 done,
  output logic                 busy,
  output logic [7:0]           overrun_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_SHIFT   = 2'd2;

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int DW = $clog2(2 * SCLK_DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [DW-1:0] DIV_MID   = DW'(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(2 * SCLK_DIV - 1);
  localparam logic [BW-1:0] BITS_ALL  = BW'(DATA_BITS);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        conv_cnt_q, conv_cnt_d;
  logic [DW-1:0]        div_q, div_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sr_x_q, sr_x_d, sr_y_q, sr_y_d;
  logic [DATA_BITS-1:0] data_x_q, data_x_d, data_y_q, data_y_d;
  logic                 cnv_q, cnv_d, sclk_q, sclk_d, done_q, done_d;
  logic [7:0]           ovr_q, ovr_d;

  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sr_x_d     = sr_x_q;
    sr_y_d     = sr_y_q;
    data_x_d   = data_x_q;
    data_y_d   = data_y_q;
    cnv_d      = cnv_q;
    sclk_d     = sclk_q;
    done_d     = done_q;
    ovr_d      = ovr_q;

    if (trigger && en && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (!en) begin
          done_d = 1'b0;
        end else if (trigger) begin
          state_d    = S_CONVERT;
          cnv_d      = 1'b1;
          done_d     = 1'b0;
          conv_cnt_d = '0;
        end
      end
      S_CONVERT: begin
        if (!en) begin
          state_d = S_IDLE;
          cnv_d   = 1'b0;
          sclk_d  = 1'b0;
          done_d  = 1'b0;
        end else if (conv_cnt_q == CONV_LAST) begin
          state_d = S_SHIFT;
          cnv_d   = 1'b0;
          bit_d   = '0;
          div_d   = '0;
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!en) begin
          state_d = S_IDLE;
          sclk_d  = 1'b0;
          done_d  = 1'b0;
        end else if ((div_q == '0) && (bit_q == BITS_ALL)) begin
          // The last period's low half has fully elapsed; hand the samples over.
          state_d  = S_IDLE;
          sclk_d   = 1'b0;
          data_x_d = sr_x_q;
          data_y_d = sr_y_q;
          done_d   = 1'b1;
        end else begin
          if (div_q == '0) begin
            sclk_d = 1'b1;
          end
          if (div_q == DIV_MID) begin
            sclk_d = 1'b0;
            sr_x_d = {sr_x_q[DATA_BITS-2:0], miso_x};
            sr_y_d = {sr_y_q[DATA_BITS-2:0], miso_y};
            bit_d  = bit_q + 1'b1;
          end
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnv_d   = 1'b0;
        sclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      conv_cnt_q <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      sr_x_q     <= '0;
      sr_y_q     <= '0;
      data_x_q   <= '0;
      data_y_q   <= '0;
      cnv_q      <= 1'b0;
      sclk_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sr_x_q     <= sr_x_d;
      sr_y_q     <= sr_y_d;
      data_x_q   <= data_x_d;
      data_y_q   <= data_y_d;
      cnv_q      <= cnv_d;
      sclk_q     <= sclk_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign cnv         = cnv_q;
  assign sclk        = sclk_q;
  assign data_x      = data_x_q;
  assign data_y      = data_y_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_eddy_sensor_reader.sv
// tb/tb_eddy_sensor_reader.sv - self-checking bench for eddy_sensor_reader
// Timeline model of one acquisition plus directed literal checks.
module tb_eddy_sensor_reader;

  localparam int DB   = 18;
  localparam int DIV  = 4;
  localparam int CONV = 200;
  localparam int LAT  = CONV + DB * 2 * DIV + 1;

  logic          clk;
  logic          rst_n;
  logic          trigger;
  logic          en;
  logic          miso_x = 1'b0;
  logic          miso_y = 1'b0;
  logic          cnv;
  logic          sclk;
  logic [DB-1:0] data_x;
  logic [DB-1:0] data_y;
  logic          done;
  logic          busy;
  logic [7:0]    overrun_cnt;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0] pat_x = '0, pat_y = '0;
  logic [DB-1:0] acq_x = '0, acq_y = '0;
  logic [DB-1:0] m_dx = '0, m_dy = '0;
  bit            m_busy = 1'b0, m_done = 1'b0, run_cmp = 1'b0;
  int            m_t = 0, m_ovr = 0;
  int            bidx = 0;

  eddy_sensor_reader #(
    .DATA_BITS  (DB),
    .SCLK_DIV   (DIV),
    .CONV_CYCLES(CONV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger    (trigger),
    .en         (en),
    .miso_x     (miso_x),
    .miso_y     (miso_y),
    .cnv        (cnv),
    .sclk       (sclk),
    .data_x     (data_x),
    .data_y     (data_y),
    .done       (done),
    .busy       (busy),
    .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC: presents the next bit MSB first on each sclk rise; cnv restarts the word.
  always @(posedge sclk or posedge cnv) begin
    if (cnv) begin
      bidx = 0;
    end else begin
      if (bidx < DB) begin
        miso_x = pat_x[DB-1-bidx];
        miso_y = pat_y[DB-1-bidx];
      end
      bidx++;
    end
  end

  // m_t counts clk edges since the accepting edge of the current acquisition.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      m_done <= 1'b0;
      m_dx   <= '0;
      m_dy   <= '0;
      m_ovr  <= 0;
    end else if (m_busy) begin
      if (!en) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
      end else begin
        if (trigger && m_ovr != 255) m_ovr <= m_ovr + 1;
        m_t <= m_t + 1;
        if (m_t + 1 == LAT) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dx   <= acq_x;
          m_dy   <= acq_y;
        end
      end
    end else if (!en) begin
      m_done <= 1'b0;
    end else if (trigger) begin
      m_busy <= 1'b1;
      m_t    <= 0;
      m_done <= 1'b0;
      acq_x  <= pat_x;
      acq_y  <= pat_y;
    end
  end

  function automatic logic exp_cnv();
    return m_busy && (m_t < CONV);
  endfunction

  function automatic logic exp_sclk();
    return m_busy && (m_t > CONV) && (((m_t - CONV - 1) % (2 * DIV)) < DIV);
  endfunction

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cyc_cnv",    32'(cnv),         32'(exp_cnv()));
      chk("cyc_sclk",   32'(sclk),        32'(exp_sclk()));
      chk("cyc_busy",   32'(busy),        32'(m_busy));
      chk("cyc_done",   32'(done),        32'(m_done));
      chk("cyc_data_x", 32'(data_x),      32'(m_dx));
      chk("cyc_data_y", 32'(data_y),      32'(m_dy));
      chk("cyc_ovr",    32'(overrun_cnt), 32'(m_ovr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    trigger = 1'b0;
    en      = 1'b0;
    tick(3);
    rst_n   = 1'b1;
    run_cmp = 1'b1;
    chk("rst_cnv",  32'(cnv),         32'd0);
    chk("rst_sclk", 32'(sclk),        32'd0);
    chk("rst_done", 32'(done),        32'd0);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_dx",   32'(data_x),      32'd0);
    chk("rst_ovr",  32'(overrun_cnt), 32'd0);

    // 1: single acquisition timing and data
    en = 1'b1; pat_x = 18'h2AAAA; pat_y = 18'h15555;
    tick(6);
    pulse_trig();
    chk("t1_cnv_start", 32'(cnv),  32'd1);
    chk("t1_busy",      32'(busy), 32'd1);
    tick(199);
    chk("t1_cnv_last",  32'(cnv),  32'd1);
    tick(1);
    chk("t1_cnv_fall",  32'(cnv),  32'd0);
    chk("t1_sclk_idle", 32'(sclk), 32'd0);
    tick(1);
    chk("t1_sclk_rise", 32'(sclk), 32'd1);
    tick(143);
    chk("t1_done_early", 32'(done), 32'd0);
    tick(1);
    chk("t1_done",   32'(done),   32'd1);
    chk("t1_dx",     32'(data_x), 32'h2AAAA);
    chk("t1_dy",     32'(data_y), 32'h15555);
    chk("t1_idle",   32'(busy),   32'd0);
    chk("t1_pulses", 32'(bidx),   32'd18);

    // 2: back to back, trigger on the completion edge counts as overrun
    pat_x = 18'h3FFFF; pat_y = 18'h00000;
    pulse_trig();
    chk("t2_done_drop", 32'(done), 32'd0);
    tick(345);
    chk("t2_dx_a", 32'(data_x), 32'h3FFFF);
    chk("t2_dy_a", 32'(data_y), 32'h00000);
    pat_x = 18'h00001; pat_y = 18'h3FFFE;
    pulse_trig();
    chk("t2_done_drop2", 32'(done), 32'd0);
    tick(344);
    pulse_trig();
    chk("t2_done_b", 32'(done),        32'd1);
    chk("t2_dx_b",   32'(data_x),      32'h00001);
    chk("t2_dy_b",   32'(data_y),      32'h3FFFE);
    chk("t2_ovr",    32'(overrun_cnt), 32'd1);
    tick(1000);
    chk("t2_done_hold", 32'(done),   32'd1);
    chk("t2_dx_hold",   32'(data_x), 32'h00001);

    // 3: busy triggers and saturation
    pat_x = 18'h12345; pat_y = 18'h2BCDE;
    pulse_trig();
    tick(49);
    pulse_trig();
    tick(200);
    pulse_trig();
    chk("t3_ovr3", 32'(overrun_cnt), 32'd3);
    tick(94);
    chk("t3_done", 32'(done),   32'd1);
    chk("t3_dx",   32'(data_x), 32'h12345);
    chk("t3_dy",   32'(data_y), 32'h2BCDE);
    pulse_trig();
    repeat (300) pulse_trig();
    chk("t3_ovr_sat",  32'(overrun_cnt), 32'd255);
    chk("t3_busy_sat", 32'(busy),        32'd1);
    tick(45);
    chk("t3_done2", 32'(done), 32'd1);

    // 4: abort mid-shift after 5 bits
    pat_x = 18'h3C3C3; pat_y = 18'h00F0F;
    pulse_trig();
    tick(241);
    chk("t4_sclk_hi", 32'(sclk), 32'd1);
    en = 1'b0;
    tick(1);
    chk("t4_cnv",  32'(cnv),    32'd0);
    chk("t4_sclk", 32'(sclk),   32'd0);
    chk("t4_busy", 32'(busy),   32'd0);
    chk("t4_done", 32'(done),   32'd0);
    chk("t4_dx",   32'(data_x), 32'h12345);
    chk("t4_dy",   32'(data_y), 32'h2BCDE);
    tick(5);
    en = 1'b1;
    pulse_trig();
    tick(345);
    chk("t4_done2", 32'(done),   32'd1);
    chk("t4_dx2",   32'(data_x), 32'h3C3C3);
    chk("t4_dy2",   32'(data_y), 32'h00F0F);

    // 5: triggers with en low after a fresh reset
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    en = 1'b0;
    repeat (3) begin
      pulse_trig();
      tick(10);
    end
    chk("t5_cnv",  32'(cnv),         32'd0);
    chk("t5_busy", 32'(busy),        32'd0);
    chk("t5_done", 32'(done),        32'd0);
    chk("t5_ovr",  32'(overrun_cnt), 32'd0);

    // 6: async reset mid-convert, then a full acquisition
    en = 1'b1; pat_x = 18'h0F0F0; pat_y = 18'h30303;
    pulse_trig();
    tick(10);
    pulse_trig();
    tick(334);
    chk("t6_pre_dx",  32'(data_x),      32'h0F0F0);
    chk("t6_pre_ovr", 32'(overrun_cnt), 32'd1);
    pat_x = 18'h1E1E1; pat_y = 18'h01234;
    pulse_trig();
    tick(100);
    chk("t6_cnv_mid", 32'(cnv), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cnv",  32'(cnv),         32'd0);
    chk("t6_rst_sclk", 32'(sclk),        32'd0);
    chk("t6_rst_busy", 32'(busy),        32'd0);
    chk("t6_rst_done", 32'(done),        32'd0);
    chk("t6_rst_dx",   32'(data_x),      32'd0);
    chk("t6_rst_dy",   32'(data_y),      32'd0);
    chk("t6_rst_ovr",  32'(overrun_cnt), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    pulse_trig();
    tick(344);
    chk("t6_done_early", 32'(done), 32'd0);
    tick(1);
    chk("t6_done", 32'(done),   32'd1);
    chk("t6_dx",   32'(data_x), 32'h1E1E1);
    chk("t6_dy",   32'(data_y), 32'h01234);
    tick(5);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
